interrupt_sequencer: RTL
========================

# interrupt_sequencer

Sequences the 7-cycle 6502 interrupt-entry microsequence (RESET, NMI, IRQ, BRK) alongside the instruction decoder. It arbitrates pending interrupt sources at instruction boundaries and takes over the address bus, stack pointer and PC-load control lines until the new PC has been loaded from the vector. The decoder resumes with FETCH once `busy` drops.

## Interface
Parameters:
- `STACK_PAGE`, default 8'h01: high address byte used for stack pushes.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  1 = advance; 0 = hold state and all outputs.
- `nmi`  in  1  active low, falling-edge triggered.
- `irq`  in  1  active low, level sensitive.
- `i_flag`  in  1  PSR interrupt-disable bit.
- `insn_done`  in  1  decoder is at an instruction boundary this cycle.
- `brk`  in  1  current opcode is BRK (8'h00); qualified by `insn_done`.
- `sp`  in  8  current stack pointer value.
- `busy`  out  1  sequencer owns bus and control lines.
- `addr_en`  out  1  `addr` drives the address bus.
- `addr`  out  16  bus address.
- `rw`  out  1  0 = read, 1 = write.
- `dout_sel`  out  2  data-out source: 0 none, 1 PCH, 2 PCL, 3 PSR.
- `b_flag`  out  1  B bit value merged into the pushed PSR.
- `sp_dec`  out  1  decrement SP at the end of this cycle.
- `set_i`  out  1  set the I flag at the end of this cycle.
- `pcl_load`  out  1  load PCL from the data bus.
- `pch_load`  out  1  load PCH from the data bus.

## Operation
- States: IDLE, DUM1, DUM2, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H. Each state lasts one enabled cycle (`rdy`=1).
- Source kind register: RESET, NMI, IRQ or BRK. Priority is RESET > NMI > BRK > IRQ.
- `rst` puts the block in IDLE and sets `rst_pend`=1.
- In IDLE, `rst_pend`=1 starts the sequence on the next cycle without needing `insn_done`.
- Otherwise, on `insn_done`=1 the highest active request starts the sequence:
  - NMI when `nmi_pend`=1.
  - BRK when `brk`=1.
  - IRQ when `irq`=0 and `i_flag`=0.
  - No active request: stay in IDLE.
- NMI edge detection:
  - `nmi_q` holds the previous sample of `nmi`.
  - `nmi_pend` sets when `nmi_q`=1 and `nmi`=0.
  - `nmi_pend` clears on entry to VEC_L when the NMI vector is selected.
  - An edge detected in that same cycle keeps `nmi_pend`=1.
- IRQ is not latched. Deasserting `irq` before `insn_done` means the IRQ is not taken.
- DUM1 and DUM2: `busy`=1, `addr_en`=0, `rw`=0.
- PUSH_H, PUSH_L and PUSH_P:
  - `addr`={STACK_PAGE, `sp`}, `addr_en`=1, `sp_dec`=1.
  - `dout_sel` = 1, 2 and 3 respectively.
  - `rw`=1, except kind RESET, where `rw`=0 and `dout_sel`=0 (SP still decrements).
- `b_flag`=1 only for kind BRK during PUSH_P; 0 otherwise.
- Vector selection is committed on entry to VEC_L:
  - RESET: 16'hFFFC.
  - NMI, or any kind with `nmi_pend`=1 (NMI hijack of IRQ/BRK): 16'hFFFA.
  - Otherwise: 16'hFFFE.
- VEC_L: `addr`=vector, `rw`=0, `pcl_load`=1, `set_i`=1.
- VEC_H: `addr`=vector+1, `rw`=0, `pch_load`=1. Next state is IDLE. `rst_pend` clears on leaving VEC_H with kind RESET.

## Timing
- Reset values of all outputs: 0, including `addr`=16'h0000. Internal reset values: `nmi_q`=1, `nmi_pend`=0.
- `rst` asserted mid-sequence aborts it immediately. No partial-sequence outputs appear in the following cycle.
- Outputs are a Moore decode of the registered state and kind, valid for the whole cycle the state is current.
- Latency: request accepted in cycle N (IDLE with `insn_done`), DUM1 in N+1, VEC_H in N+7, IDLE (`busy`=0) in N+8.
- `rdy`=0 freezes the state, outputs, `nmi_pend` setting and `nmi_q`. A falling NMI edge that occurs while `rdy`=0 is seen once `rdy` returns.
- `sp` is sampled combinationally, so the SPR update from `sp_dec` must land before the next push cycle.
- A request arriving while `busy`=1 is ignored, except an NMI edge, which is latched in `nmi_pend`.

## Test plan
- Reset: `rst` for 2 cycles, then release:
  - 7 busy cycles; three push cycles at 16'h01FD/FC/FB with `sp`=FD/FC/FB, each with `rw`=0.
  - VEC_L `addr`=FFFC, VEC_H `addr`=FFFD; `busy`=0 on cycle 8.
- IRQ gating:
  - `irq`=0, `i_flag`=1, `insn_done`: no sequence.
  - With `i_flag`=0: pushes H/L/P (`rw`=1, `b_flag`=0), vector FFFE/FFFF, `set_i`=1 in VEC_L.
- NMI edge:
  - `nmi` 1->0 and held low across two instructions: exactly one sequence, vector FFFA.
  - Second falling edge after `nmi` returns to 1: a second sequence.
- BRK hijack: `brk`=1 at `insn_done`, then `nmi` falls during PUSH_L:
  - PUSH_P has `b_flag`=1; VEC_L uses FFFA; `nmi_pend`=0 afterwards.
- Stall: `rdy`=0 for 3 cycles during PUSH_H:
  - `addr`, `rw` and `sp_dec` hold; total sequence length becomes 10 cycles.
- Reset abort: `rst` during VEC_L of an IRQ sequence:
  - Next cycle all outputs are 0; after release, a full RESET sequence with vector FFFC runs.

Source files
------------

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
// interrupt_sequencer_if
// Decoder-side control/bus bundle for the 6502 interrupt-entry sequencer.
// Revision: 1.0
// ============================================================================
interface interrupt_sequencer_if;
  logic       rdy;
  logic       nmi;
  logic       irq;
  logic       i_flag;
  logic       insn_done;
  logic       brk;
  logic [7:0] sp;

  logic        busy;
  logic        addr_en;
  logic [15:0] addr;
  logic        rw;
  logic [1:0]  dout_sel;
  logic        b_flag;
  logic        sp_dec;
  logic        set_i;
  logic        pcl_load;
  logic        pch_load;

  modport master (
    input  rdy, nmi, irq, i_flag, insn_done, brk, sp,
    output busy, addr_en, addr, rw, dout_sel, b_flag, sp_dec, set_i,
           pcl_load, pch_load
  );

  modport slave (
    output rdy, nmi, irq, i_flag, insn_done, brk, sp,
    input  busy, addr_en, addr, rw, dout_sel, b_flag, sp_dec, set_i,
           pcl_load, pch_load
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// interrupt_sequencer
// 7-cycle 6502 interrupt entry (RESET/NMI/IRQ/BRK): arbitration, stack pushes
// and vector fetch, driving bus and PC-load control while busy.
// Revision: 1.0
// ============================================================================
module interrupt_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input logic                   clk,
  input logic                   rst,
  interrupt_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DUM1   = 3'd1,
    S_DUM2   = 3'd2,
    S_PUSH_H = 3'd3,
    S_PUSH_L = 3'd4,
    S_PUSH_P = 3'd5,
    S_VEC_L  = 3'd6,
    S_VEC_H  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    K_RESET = 2'd0,
    K_NMI   = 2'd1,
    K_IRQ   = 2'd2,
    K_BRK   = 2'd3
  } kind_t;

  state_t      r_state, w_next_state;
  kind_t       r_kind, w_next_kind;
  logic        r_rst_pend;
  logic        r_nmi_q;
  logic        r_nmi_pend;
  logic [15:0] r_vector;

  logic w_kind_rst;
  logic w_vec_nmi;
  logic w_nmi_edge;

  assign w_kind_rst = (r_kind == K_RESET);
  assign w_vec_nmi  = (r_kind == K_NMI) || r_nmi_pend;
  assign w_nmi_edge = r_nmi_q && !bus.nmi;

  always_comb begin
    w_next_state = r_state;
    w_next_kind  = r_kind;
    case (r_state)
      S_IDLE: begin
        if (r_rst_pend) begin
          w_next_state = S_DUM1;
          w_next_kind  = K_RESET;
        end else if (bus.insn_done) begin
          if (r_nmi_pend) begin
            w_next_state = S_DUM1;
            w_next_kind  = K_NMI;
          end else if (bus.brk) begin
            w_next_state = S_DUM1;
            w_next_kind  = K_BRK;
          end else if (!bus.irq && !bus.i_flag) begin
            w_next_state = S_DUM1;
            w_next_kind  = K_IRQ;
          end
        end
      end
      S_DUM1:   w_next_state = S_DUM2;
      S_DUM2:   w_next_state = S_PUSH_H;
      S_PUSH_H: w_next_state = S_PUSH_L;
      S_PUSH_L: w_next_state = S_PUSH_P;
      S_PUSH_P: w_next_state = S_VEC_L;
      S_VEC_L:  w_next_state = S_VEC_H;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_kind     <= K_RESET;
      r_rst_pend <= 1'b1;
      r_nmi_q    <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_vector   <= 16'h0000;
    end else if (bus.rdy) begin
      r_state <= w_next_state;
      r_kind  <= w_next_kind;
      r_nmi_q <= bus.nmi;
      // A fresh edge wins over the clear so a back-to-back NMI is not lost.
      if (w_nmi_edge)
        r_nmi_pend <= 1'b1;
      else if (r_state == S_PUSH_P && !w_kind_rst && w_vec_nmi)
        r_nmi_pend <= 1'b0;
      if (r_state == S_PUSH_P) begin
        if (w_kind_rst)
          r_vector <= 16'hFFFC;
        else if (w_vec_nmi)
          r_vector <= 16'hFFFA;
        else
          r_vector <= 16'hFFFE;
      end
      if (r_state == S_VEC_H && w_kind_rst)
        r_rst_pend <= 1'b0;
    end
  end

  logic        w_busy, w_addr_en, w_rw, w_b_flag, w_sp_dec, w_set_i;
  logic        w_pcl_load, w_pch_load;
  logic [15:0] w_addr;
  logic [1:0]  w_dout_sel;

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_addr_en  = 1'b0;
    w_addr     = 16'h0000;
    w_rw       = 1'b0;
    w_dout_sel = 2'd0;
    w_b_flag   = 1'b0;
    w_sp_dec   = 1'b0;
    w_set_i    = 1'b0;
    w_pcl_load = 1'b0;
    w_pch_load = 1'b0;
    case (r_state)
      S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
        w_addr_en = 1'b1;
        w_addr    = {STACK_PAGE, bus.sp};
        w_sp_dec  = 1'b1;
        // RESET walks the stack with reads only; nothing is written.
        w_rw      = !w_kind_rst;
        if (!w_kind_rst) begin
          if (r_state == S_PUSH_H)      w_dout_sel = 2'd1;
          else if (r_state == S_PUSH_L) w_dout_sel = 2'd2;
          else                          w_dout_sel = 2'd3;
        end
        w_b_flag  = (r_state == S_PUSH_P) && (r_kind == K_BRK);
      end
      S_VEC_L: begin
        w_addr_en  = 1'b1;
        w_addr     = r_vector;
        w_set_i    = 1'b1;
        w_pcl_load = 1'b1;
      end
      S_VEC_H: begin
        w_addr_en  = 1'b1;
        w_addr     = r_vector | 16'h0001;
        w_pch_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy     = w_busy;
  assign bus.addr_en  = w_addr_en;
  assign bus.addr     = w_addr;
  assign bus.rw       = w_rw;
  assign bus.dout_sel = w_dout_sel;
  assign bus.b_flag   = w_b_flag;
  assign bus.sp_dec   = w_sp_dec;
  assign bus.set_i    = w_set_i;
  assign bus.pcl_load = w_pcl_load;
  assign bus.pch_load = w_pch_load;

endmodule
`default_nettype wire
